bullet_fire_ctrl: RTL and testbench
===================================

Name: bullet_fire_ctrl

Overview:
- Producer/writer side of the bullet FIFO. The bullet path's consumer pops `{x, y, orientation}` records from that FIFO.
- Turns the raw player fire button into single, rate-limited, ammo-limited bullet launch records.
- Pushes those records into the bullet FIFO with full-flag backpressure.
- Sits between the board button/sprite-position logic and the bullet FIFO write port.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required before the debounced button changes (10 ms at 100 MHz).
- COOLDOWN_CYCLES, 25_000_000, minimum cycles from a FIFO write back to IDLE (rate limit).
- MAX_AMMO, 8, magazine size; ammo width AW = $clog2(MAX_AMMO+1).
- DATA_WIDTH, 24, record width; fixed format `{x[10:0], y[10:0], orientation[1:0]}`.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- btn_fire  in  1  raw, asynchronous, bouncy fire button, active-high
- orientation  in  2  current player facing
- sprite_x  in  11  current player x
- sprite_y  in  11  current player y
- reload  in  1  single-cycle pulse; refills ammo
- fifo_full  in  1  bullet FIFO full flag
- fire_wr  out  1  FIFO write strobe
- fire_data  out  DATA_WIDTH  FIFO write data
- ammo  out  AW  rounds remaining
- busy  out  1  high when state != IDLE
- dry_fire  out  1  one-cycle pulse on a press with ammo==0

Behaviour:
- **Reset** (reset==0, async): state=IDLE; sync/debounce regs=0; btn_db=0; fire_data=0; fire_wr=0; busy=0; dry_fire=0; cooldown counter=0; ammo=MAX_AMMO.
- **Synchronizer:** 2-FF synchronizer on btn_fire gives btn_s.
- **Debounce:** a counter runs while btn_s != btn_db and clears whenever they are equal. After DEBOUNCE_CYCLES consecutive mismatch cycles, btn_db <= btn_s and the counter clears. Glitches shorter than DEBOUNCE_CYCLES never change btn_db.
- **Press event:** press = btn_db & ~btn_db_q, one cycle wide. Release edges are ignored.
- **FSM:**
  - IDLE:
    - press with ammo>0: fire_data <= `{sprite_x, sprite_y, orientation}`, sampled in the press cycle; go to ISSUE.
    - press with ammo==0: dry_fire=1 for that cycle only; stay in IDLE.
  - ISSUE:
    - fire_wr = ~fifo_full (combinational from state).
    - When fire_wr=1: ammo decrements; cooldown counter loads COOLDOWN_CYCLES-1; go to COOLDOWN.
    - While fifo_full=1: hold in ISSUE; fire_data stays frozen; sprite/orientation changes are ignored.
  - COOLDOWN: counter decrements each cycle; at 0, go to IDLE.
  - COOLDOWN_CYCLES=0 or 1: go straight to IDLE on the next cycle.
- **Latency:** press cycle N, then fire_wr in cycle N+1 if not full.
- **Writes per press:** exactly one fire_wr pulse, never more.
- **Presses outside IDLE:** presses in ISSUE or COOLDOWN are discarded, not queued. A button still held at return to IDLE does not fire; a new rising edge is required.
- **Reload:** ammo <= MAX_AMMO in any state. If reload coincides with fire_wr, reload wins and ammo=MAX_AMMO. Reload never triggers or cancels an ISSUE.
- **ammo bounds:** never decrements below 0; never exceeds MAX_AMMO.
- **fire_data:** changes only on IDLE→ISSUE capture.
- **Reset mid-operation:** an in-flight ISSUE is abandoned with no write; the pending record is lost.

Test Plan:
(Bench parameters: DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=10, MAX_AMMO=3.)
1. Clean press: btn_fire high 20 cycles, sprite_x=100, sprite_y=200, orientation=2, fifo_full=0 → exactly one fire_wr pulse; fire_data=0x0C8322; ammo 3→2; busy high for 11 cycles, then low.
2. Bounce: btn_fire toggles with 1- and 3-cycle highs separated by 1-cycle lows for 30 cycles, never stable for 4 cycles → btn_db stays 0; no fire_wr; ammo=3.
3. Backpressure: fifo_full=1 before the press and held 5 cycles after ISSUE entry, while sprite_x changes to 300 → fire_wr=0 for those 5 cycles; fire_data still holds x=100; single fire_wr on the first cycle fifo_full=0.
4. Rate limit: second clean press 3 cycles after fire_wr → ignored (one write total); release, then press again after busy falls → second write, ammo=1.
5. Ammo: 3 spaced presses → 3 writes, ammo=0. 4th press → dry_fire single pulse, no fire_wr. reload pulse → ammo=3. Press then reload asserted in the fire_wr cycle → ammo=3 after that cycle.
6. Reset mid-ISSUE: fifo_full=1 holding ISSUE, assert reset low for 2 cycles, release, drop fifo_full → no fire_wr; ammo=3; busy=0; fire_data=0.

Source files
------------

// File: rtl/bullet_fire_ctrl_if.sv
// Bullet FIFO write-port bundle.
//   fire_wr   : write strobe, one cycle per record (master -> slave)
//   fire_data : {x[10:0], y[10:0], orientation[1:0]} record (master -> slave)
//   fifo_full : FIFO full flag (slave -> master)
// Handshake: a record transfers in every cycle where fire_wr is high. The
// master raises fire_wr only while fifo_full is low, so a write is never
// offered into a full FIFO. fire_data is stable whenever fire_wr is high.
interface bullet_fire_ctrl_if #(
  parameter int DATA_WIDTH = 24
);
  logic                  fire_wr;
  logic [DATA_WIDTH-1:0] fire_data;
  logic                  fifo_full;

  modport master (
    output fire_wr,
    output fire_data,
    input  fifo_full
  );

  modport slave (
    input  fire_wr,
    input  fire_data,
    output fifo_full
  );
endinterface

// File: rtl/bullet_fire_ctrl.sv
// Bullet fire controller: turns the raw fire button into single,
// rate-limited, ammo-limited launch records pushed into the bullet FIFO.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   btn_fire        : raw asynchronous bouncy fire button (active-high)
//   orientation     : player facing, captured on a press
//   sprite_x/y      : player position, captured on a press
//   reload          : single-cycle pulse, refills the magazine
//   fifo            : bullet FIFO write port (master side)
//   ammo            : rounds remaining
//   busy            : high whenever the FSM is not idle
//   dry_fire        : one-cycle pulse on a press with an empty magazine
//   dbg_state_o     : current FSM state for observation
module bullet_fire_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int COOLDOWN_CYCLES = 25_000_000,
  parameter int MAX_AMMO        = 8,
  parameter int DATA_WIDTH      = 24,
  localparam int AW = $clog2(MAX_AMMO + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   btn_fire,
  input  logic [1:0]             orientation,
  input  logic [10:0]            sprite_x,
  input  logic [10:0]            sprite_y,
  input  logic                   reload,
  bullet_fire_ctrl_if.master     fifo,
  output logic [AW-1:0]          ammo,
  output logic                   busy,
  output logic                   dry_fire,
  output logic [1:0]             dbg_state_o
);

  localparam int DW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CW = (COOLDOWN_CYCLES < 2) ? 1 : $clog2(COOLDOWN_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);
  localparam logic [CW-1:0] COOL_LOAD = CW'((COOLDOWN_CYCLES > 0) ? COOLDOWN_CYCLES - 1 : 0);
  localparam logic [AW-1:0] AMMO_FULL = AW'(MAX_AMMO);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_COOLDOWN = 2'd2
  } state_t;

  state_t                state_q;
  logic                  sync1_q, sync2_q;
  logic                  btn_db_q, btn_db_prev_q;
  logic [DW-1:0]         db_cnt_q;
  logic [CW-1:0]         cool_cnt_q;
  logic [AW-1:0]         ammo_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  press;
  logic                  wr;

  // Two-flop synchronizer followed by a stability counter. The counter only
  // advances while the synchronized input disagrees with the debounced level,
  // so any return to agreement restarts the whole qualification window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      btn_db_q      <= 1'b0;
      btn_db_prev_q <= 1'b0;
      db_cnt_q      <= '0;
    end else begin
      sync1_q       <= btn_fire;
      sync2_q       <= sync1_q;
      btn_db_prev_q <= btn_db_q;
      if (sync2_q == btn_db_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q >= DB_LAST) begin
        btn_db_q <= sync2_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  // Rising edge of the debounced level only; releases never fire.
  assign press = btn_db_q & ~btn_db_prev_q;

  // The write strobe is a pure decode of the ISSUE state gated by the full
  // flag, so it can never be offered into a full FIFO.
  assign wr = (state_q == S_ISSUE) & ~fifo.fifo_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cool_cnt_q <= '0;
      ammo_q     <= AMMO_FULL;
      data_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (press && ammo_q != '0) begin
            data_q  <= DATA_WIDTH'({sprite_x, sprite_y, orientation});
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (wr) begin
            cool_cnt_q <= COOL_LOAD;
            // Cooldown lengths of 0 or 1 skip the countdown entirely.
            state_q    <= (COOLDOWN_CYCLES <= 1) ? S_IDLE : S_COOLDOWN;
          end
        end
        S_COOLDOWN: begin
          if (cool_cnt_q == '0) begin
            state_q <= S_IDLE;
          end else begin
            cool_cnt_q <= cool_cnt_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Reload has priority over a same-cycle decrement.
      if (reload) begin
        ammo_q <= AMMO_FULL;
      end else if (wr && ammo_q != '0) begin
        ammo_q <= ammo_q - 1'b1;
      end
    end
  end

  assign fifo.fire_wr   = wr;
  assign fifo.fire_data = data_q;
  assign ammo           = ammo_q;
  assign busy           = (state_q != S_IDLE);
  assign dry_fire       = (state_q == S_IDLE) & press & (ammo_q == '0);
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_bullet_fire_ctrl.sv
module tb_bullet_fire_ctrl;

  localparam int DW = 24;
  localparam int AW = 2;

  logic          clk;
  logic          reset;
  logic          btn_fire;
  logic [1:0]    orientation;
  logic [10:0]   sprite_x;
  logic [10:0]   sprite_y;
  logic          reload;
  logic [AW-1:0] ammo;
  logic          busy;
  logic          dry_fire;
  logic [1:0]    dbg_state;

  bullet_fire_ctrl_if #(.DATA_WIDTH(DW)) fifo_if ();

  bullet_fire_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .COOLDOWN_CYCLES(10),
    .MAX_AMMO(3),
    .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_fire(btn_fire),
    .orientation(orientation),
    .sprite_x(sprite_x),
    .sprite_y(sprite_y),
    .reload(reload),
    .fifo(fifo_if.master),
    .ammo(ammo),
    .busy(busy),
    .dry_fire(dry_fire),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  int vectors    = 0;
  int miscompares = 0;
  int wr_count   = 0;
  int dry_count  = 0;
  int dry_exp    = 0;
  int busy_run   = 0;
  int last_busy_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rec(input logic [10:0] x, input logic [10:0] y,
                                        input logic [1:0] o);
    return {x, y, o};
  endfunction

  // Monitor: pops one expected record per observed write strobe.
  always @(negedge clk) begin
    if (!reset) begin
      busy_run <= 0;
    end else begin
      if (fifo_if.fire_wr) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got 0x%0h expected no write", fifo_if.fire_data);
        end else begin
          check("write_record", 32'(fifo_if.fire_data), 32'(exp_q.pop_front()));
        end
      end
      if (dry_fire) dry_count++;
      if (busy) begin
        busy_run <= busy_run + 1;
      end else if (busy_run != 0) begin
        last_busy_run <= busy_run;
        busy_run      <= 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_btn(input int hold);
    btn_fire = 1'b1;
    repeat (hold) tick();
    btn_fire = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
    tick();
  endtask

  task automatic wait_busy(input logic level, input int budget, input string name);
    int n = 0;
    while (busy !== level && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(busy), 32'(level));
  endtask

  task automatic wait_wr(input int budget, input string name);
    int n = 0;
    while (fifo_if.fire_wr !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(fifo_if.fire_wr), 32'd1);
  endtask

  // Lets a press work through, waits for idle, then lets the release settle.
  task automatic settle(input string name);
    repeat (4) tick();
    wait_busy(1'b0, 60, name);
    repeat (12) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int wr0;
    int db_hi;
    logic pattern [6];

    reset = 1'b0;
    btn_fire = 1'b0;
    orientation = 2'd2;
    sprite_x = 11'd100;
    sprite_y = 11'd200;
    reload = 1'b0;
    fifo_if.fifo_full = 1'b0;
    repeat (3) tick();

    check("reset_ammo", 32'(ammo), 32'd3);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_fire_wr", 32'(fifo_if.fire_wr), 32'd0);
    check("reset_fire_data", 32'(fifo_if.fire_data), 32'd0);
    check("reset_dry_fire", 32'(dry_fire), 32'd0);
    reset = 1'b1;
    repeat (2) tick();

    // 1. Clean press.
    wr0 = wr_count;
    exp_q.push_back(24'h0C8322);
    press_btn(20);
    settle("t1_idle");
    check("t1_writes", 32'(wr_count - wr0), 32'd1);
    check("t1_ammo", 32'(ammo), 32'd2);
    check("t1_busy_len", 32'(last_busy_run), 32'd11);
    check("t1_data_hold", 32'(fifo_if.fire_data), 32'h0C8322);

    // 2. Bounce never stable for 4 cycles.
    pulse_reload();
    wr0 = wr_count;
    pattern[0] = 1'b1; pattern[1] = 1'b0; pattern[2] = 1'b1;
    pattern[3] = 1'b1; pattern[4] = 1'b1; pattern[5] = 1'b0;
    db_hi = 0;
    for (int i = 0; i < 30; i++) begin
      btn_fire = pattern[i % 6];
      tick();
      if (dut.btn_db_q) db_hi++;
    end
    btn_fire = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (dut.btn_db_q) db_hi++;
    end
    check("t2_btn_db_high_cycles", 32'(db_hi), 32'd0);
    check("t2_writes", 32'(wr_count - wr0), 32'd0);
    check("t2_ammo", 32'(ammo), 32'd3);

    // 3. Backpressure holds ISSUE with the captured record frozen.
    wr0 = wr_count;
    fifo_if.fifo_full = 1'b1;
    exp_q.push_back(rec(11'd100, 11'd200, 2'd2));
    press_btn(5);
    wait_busy(1'b1, 20, "t3_enter_issue");
    sprite_x = 11'd300;
    for (int i = 0; i < 5; i++) begin
      check("t3_no_wr_full", 32'(fifo_if.fire_wr), 32'd0);
      check("t3_data_frozen", 32'(fifo_if.fire_data), 32'(rec(11'd100, 11'd200, 2'd2)));
      tick();
    end
    check("t3_still_busy", 32'(busy), 32'd1);
    fifo_if.fifo_full = 1'b0;
    #1;
    check("t3_wr_on_release", 32'(fifo_if.fire_wr), 32'd1);
    settle("t3_idle");
    check("t3_writes", 32'(wr_count - wr0), 32'd1);
    sprite_x = 11'd100;

    // 4. Rate limit: a press during cooldown is discarded.
    pulse_reload();
    wr0 = wr_count;
    orientation = 2'd1;
    sprite_x = 11'd5;
    sprite_y = 11'd7;
    exp_q.push_back(rec(11'd5, 11'd7, 2'd1));
    press_btn(5);
    wait_wr(20, "t4_first_wr");
    repeat (3) tick();
    press_btn(5);
    settle("t4_idle_a");
    check("t4_writes_after_ignored", 32'(wr_count - wr0), 32'd1);
    sprite_x = 11'd2047;
    sprite_y = 11'd0;
    orientation = 2'd3;
    exp_q.push_back(rec(11'd2047, 11'd0, 2'd3));
    press_btn(5);
    settle("t4_idle_b");
    check("t4_writes", 32'(wr_count - wr0), 32'd2);
    check("t4_ammo", 32'(ammo), 32'd1);

    // 5. Ammo exhaustion, dry fire, reload priority.
    pulse_reload();
    wr0 = wr_count;
    for (int i = 0; i < 3; i++) begin
      sprite_x = 11'(10 + i);
      exp_q.push_back(rec(sprite_x, sprite_y, orientation));
      press_btn(5);
      settle("t5_idle_shot");
    end
    check("t5_writes", 32'(wr_count - wr0), 32'd3);
    check("t5_ammo_empty", 32'(ammo), 32'd0);
    dry_exp = dry_count + 1;
    press_btn(5);
    settle("t5_idle_dry");
    check("t5_dry_pulses", 32'(dry_count), 32'(dry_exp));
    check("t5_no_wr_dry", 32'(wr_count - wr0), 32'd3);
    check("t5_ammo_still_empty", 32'(ammo), 32'd0);
    pulse_reload();
    check("t5_ammo_reloaded", 32'(ammo), 32'd3);
    exp_q.push_back(rec(sprite_x, sprite_y, orientation));
    press_btn(5);
    wait_wr(20, "t5_wr_for_reload");
    reload = 1'b1;
    tick();
    reload = 1'b0;
    check("t5_reload_wins", 32'(ammo), 32'd3);
    settle("t5_idle_end");
    check("t5_writes_total", 32'(wr_count - wr0), 32'd4);

    // 6. Reset while ISSUE is held by backpressure.
    wr0 = wr_count;
    fifo_if.fifo_full = 1'b1;
    press_btn(5);
    wait_busy(1'b1, 20, "t6_enter_issue");
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    fifo_if.fifo_full = 1'b0;
    repeat (20) tick();
    check("t6_no_write", 32'(wr_count - wr0), 32'd0);
    check("t6_ammo", 32'(ammo), 32'd3);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_fire_data", 32'(fifo_if.fire_data), 32'd0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
